// File: rtl/photo_sram_loader.sv
// photo_sram_loader: accepts an RGB888 raster stream over valid/ready, computes
// an 8-bit gray value per pixel and writes each pixel as two 16-bit SRAM words
// into one photo slot: word0 = {R,G} at base+2k, word1 = {B,gray} at base+2k+1.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_start             start loading one photo (sampled only when idle)
//   i_photo_sel         slot index; base = sel*2*cols*rows
//   iCol_Max, iRow_Max  photo width / height in pixels
//   i_valid, i_R/G/B    pixel stream input
//   o_ready             pixel accepted when i_valid & o_ready
//   oSRAM_WE_N/OE_N     SRAM strobes (OE_N held high, write-only)
//   oSRAM_ADDR/DATA     SRAM word address / bidirectional data
//   o_busy, o_done      activity flag / one-cycle completion pulse
//   o_col, o_row        coordinates of the pixel being written
module photo_sram_loader #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_photo_sel,
  input  logic [9:0]        iCol_Max,
  input  logic [9:0]        iRow_Max,
  input  logic              i_valid,
  input  logic [7:0]        i_R,
  input  logic [7:0]        i_G,
  input  logic [7:0]        i_B,
  output logic              o_ready,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  inout  wire  [15:0]       oSRAM_DATA,
  output logic              o_busy,
  output logic              o_done,
  output logic [9:0]        o_col,
  output logic [9:0]        o_row
);

  localparam int unsigned DIM_W  = 10;
  localparam int unsigned PS_W   = 20;
  localparam int unsigned BASE_W = 23;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_W0, S_W1, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    cmax_q, cmax_d, rmax_q, rmax_d;
  logic [DIM_W-1:0]    col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [PS_W-1:0]     k_q, k_d;
  logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d, gray_q, gray_d;
  logic                ready_q, ready_d, we_n_q, we_n_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic [PS_W-1:0]     ps_c;
  logic [BASE_W-1:0]   base_full_c;
  logic [15:0]         gray_sum_c;
  logic [7:0]          gray_new_c;
  logic                accept_c, last_c, last_d;
  logic [ADDR_W-1:0]   addr_w0_c;

  // Gray from the live input; only captured on handshake cycles.
  assign gray_sum_c = 16'(16'd77 * 16'(i_R)) + 16'(16'd150 * 16'(i_G)) + 16'(16'd29 * 16'(i_B));
  assign gray_new_c = 8'(gray_sum_c >> 8);

  assign ps_c        = PS_W'(PS_W'(iCol_Max) * PS_W'(iRow_Max));
  assign base_full_c = BASE_W'(BASE_W'(i_photo_sel) * BASE_W'({ps_c, 1'b0}));
  assign accept_c    = i_valid && ready_q;
  assign last_c      = (col_q == cmax_q - DIM_W'(1)) && (row_q == rmax_q - DIM_W'(1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    cmax_d  = cmax_q;
    rmax_d  = rmax_q;
    base_d  = base_q;
    col_d   = col_q;
    row_d   = row_q;
    k_d     = k_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    gray_d  = gray_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          cmax_d  = iCol_Max;
          rmax_d  = iRow_Max;
          base_d  = ADDR_W'(base_full_c);
          col_d   = '0;
          row_d   = '0;
          k_d     = '0;
          state_d = (ps_c == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (accept_c) begin
          r_d     = i_R;
          g_d     = i_G;
          b_d     = i_B;
          gray_d  = gray_new_c;
          state_d = S_W0;
        end
      end
      S_W0: state_d = S_W1;
      S_W1: begin
        if (last_c) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + PS_W'(1);
          if (col_q == cmax_q - DIM_W'(1)) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (accept_c) begin
            r_d     = i_R;
            g_d     = i_G;
            b_d     = i_B;
            gray_d  = gray_new_c;
            state_d = S_W0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    last_d    = (col_d == cmax_d - DIM_W'(1)) && (row_d == rmax_d - DIM_W'(1));
    addr_w0_c = base_d + ADDR_W'({k_d, 1'b0});
    we_n_d    = !((state_d == S_W0) || (state_d == S_W1));
    ready_d   = (state_d == S_WAIT) || ((state_d == S_W1) && !last_d);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    addr_d    = '0;
    data_d    = '0;
    if (state_d == S_W0) begin
      addr_d = addr_w0_c;
      data_d = {r_d, g_d};
    end else if (state_d == S_W1) begin
      addr_d = addr_w0_c + ADDR_W'(1);
      data_d = {b_d, gray_d};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmax_q  <= '0;
      rmax_q  <= '0;
      base_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      k_q     <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      gray_q  <= '0;
      ready_q <= 1'b0;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cmax_q  <= cmax_d;
      rmax_q  <= rmax_d;
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
      k_q     <= k_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      gray_q  <= gray_d;
      ready_q <= ready_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign o_ready    = ready_q;
  assign oSRAM_WE_N = we_n_q;
  assign oSRAM_OE_N = 1'b1;
  assign oSRAM_ADDR = addr_q;
  assign oSRAM_DATA = we_n_q ? 16'bz : data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_col      = col_q;
  assign o_row      = row_q;

endmodule

// File: tb/tb_photo_sram_loader.sv
// Directed bench for photo_sram_loader: records every SRAM write and checks
// addresses, data, coordinates, handshake duty and done/reset behaviour.
module tb_photo_sram_loader;

  localparam int unsigned ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [1:0]        i_photo_sel = '0;
  logic [9:0]        iCol_Max = '0;
  logic [9:0]        iRow_Max = '0;
  logic              i_valid = 1'b0;
  logic [7:0]        i_R = '0, i_G = '0, i_B = '0;
  logic              o_ready, oSRAM_WE_N, oSRAM_OE_N, o_busy, o_done;
  logic [ADDR_W-1:0] oSRAM_ADDR;
  wire  [15:0]       sram_data;
  logic [9:0]        o_col, o_row;

  photo_sram_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_photo_sel(i_photo_sel),
    .iCol_Max(iCol_Max), .iRow_Max(iRow_Max), .i_valid(i_valid),
    .i_R(i_R), .i_G(i_G), .i_B(i_B), .o_ready(o_ready),
    .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_OE_N(oSRAM_OE_N), .oSRAM_ADDR(oSRAM_ADDR),
    .oSRAM_DATA(sram_data), .o_busy(o_busy), .o_done(o_done),
    .o_col(o_col), .o_row(o_row)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write recorder; owned solely by this process.
  logic [ADDR_W-1:0] wr_addr [256];
  logic [15:0]       wr_data [256];
  logic [9:0]        wr_col  [256];
  logic [9:0]        wr_row  [256];
  int wr_n = 0, done_cnt = 0, ready_cnt = 0;

  always @(negedge clk) begin
    if (!oSRAM_WE_N && wr_n < 256) begin
      wr_addr[wr_n] = oSRAM_ADDR;
      wr_data[wr_n] = sram_data;
      wr_col[wr_n]  = o_col;
      wr_row[wr_n]  = o_row;
      wr_n++;
    end
    if (o_done) done_cnt++;
    if (o_ready && o_busy) ready_cnt++;
  end

  logic [7:0] px_r [16], px_g [16], px_b [16];

  function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int s;
    s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
    return 8'(s >> 8);
  endfunction

  // Called just after a negedge; returns just after a negedge with i_start low.
  task automatic start(input logic [1:0] sel, input logic [9:0] cm, input logic [9:0] rm);
    i_photo_sel = sel; iCol_Max = cm; iRow_Max = rm; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic send(input int idx, input int gap);
    int t;
    repeat (gap) begin i_valid = 1'b0; @(negedge clk); end
    i_valid = 1'b1; i_R = px_r[idx]; i_G = px_g[idx]; i_B = px_b[idx];
    t = 0;
    while (!o_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("ready_timeout", 32'(t), 0);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 300) begin @(negedge clk); #1; t++; end
    check("done_seen", 32'(done_cnt >= target), 1);
    @(negedge clk); #1;
    check("idle_after_done", 32'(o_busy), 0);
  endtask

  task automatic check_photo(input string tag, input int first, input int npix,
                             input int base, input int cm);
    check({tag, "_nwr"}, 32'(wr_n - first), 32'(2 * npix));
    for (int i = 0; i < npix; i++) begin
      check({tag, "_a0"}, 32'(wr_addr[first + 2*i]),     32'(base + 2*i));
      check({tag, "_d0"}, 32'(wr_data[first + 2*i]),     {16'h0, px_r[i], px_g[i]});
      check({tag, "_a1"}, 32'(wr_addr[first + 2*i + 1]), 32'(base + 2*i + 1));
      check({tag, "_d1"}, 32'(wr_data[first + 2*i + 1]), {16'h0, px_b[i], gray_of(px_r[i], px_g[i], px_b[i])});
      check({tag, "_col"}, 32'(wr_col[first + 2*i + 1]), 32'(i % cm));
      check({tag, "_row"}, 32'(wr_row[first + 2*i + 1]), 32'(i / cm));
    end
  endtask

  logic [15:0] t1_data [8] = '{16'hFFFF, 16'hFFFF, 16'h6400, 16'h001E,
                               16'h0000, 16'h0000, 16'h0102, 16'h0301};

  initial begin
    int f, d0, r0, n0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 0);
    check("rst_we_n", 32'(oSRAM_WE_N), 1);
    check("rst_oe_n", 32'(oSRAM_OE_N), 1);
    check("rst_addr", 32'(oSRAM_ADDR), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_colrow", {12'h0, o_col, o_row}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 2x2, slot 0, hand-computed words
    px_r[0] = 8'd255; px_g[0] = 8'd255; px_b[0] = 8'd255;
    px_r[1] = 8'd100; px_g[1] = 8'd0;   px_b[1] = 8'd0;
    px_r[2] = 8'd0;   px_g[2] = 8'd0;   px_b[2] = 8'd0;
    px_r[3] = 8'd1;   px_g[3] = 8'd2;   px_b[3] = 8'd3;
    f = wr_n; d0 = done_cnt;
    start(2'd0, 10'd2, 10'd2);
    for (int i = 0; i < 4; i++) send(i, 0);
    wait_done(d0 + 1);
    check("t1_nwr", 32'(wr_n - f), 8);
    for (int i = 0; i < 8; i++) begin
      check("t1_addr", 32'(wr_addr[f + i]), 32'(i));
      check("t1_data", 32'(wr_data[f + i]), 32'(t1_data[i]));
    end
    check("t1_done_once", 32'(done_cnt - d0), 1);

    // 2: 4x3, slot 1, back-to-back stream
    for (int i = 0; i < 12; i++) begin
      px_r[i] = 8'(i * 20); px_g[i] = 8'(255 - i * 13); px_b[i] = 8'(i * 7 + 5);
    end
    f = wr_n; d0 = done_cnt; r0 = ready_cnt;
    start(2'd1, 10'd4, 10'd3);
    for (int i = 0; i < 12; i++) send(i, 0);
    wait_done(d0 + 1);
    check_photo("t2", f, 12, 24, 4);
    check("t2_first", 32'(wr_addr[f]), 24);
    check("t2_last", 32'(wr_addr[f + 23]), 47);
    check("t2_ready_cycles", 32'(ready_cnt - r0), 12);

    // 3: 3x2, slot 2, gapped valid (3 low, 1 high)
    for (int i = 0; i < 6; i++) begin
      px_r[i] = 8'(200 - i * 30); px_g[i] = 8'(i * 41); px_b[i] = 8'(i * 50 + 3);
    end
    f = wr_n; d0 = done_cnt;
    start(2'd2, 10'd3, 10'd2);
    for (int i = 0; i < 6; i++) begin
      send(i, 3);
      if (i == 2) begin
        repeat (2) @(negedge clk);
        #1;
        check("t3_park_we_n", 32'(oSRAM_WE_N), 1);
        check("t3_park_ready", 32'(o_ready), 1);
      end
    end
    wait_done(d0 + 1);
    check_photo("t3", f, 6, 24, 3);

    // 4: zero-size photo
    f = wr_n; d0 = done_cnt;
    start(2'd1, 10'd0, 10'd5);
    #1;
    check("t4_done_pulse", 32'(o_done), 1);
    @(negedge clk); #1;
    check("t4_done_low", 32'(o_done), 0);
    check("t4_idle", 32'(o_busy), 0);
    check("t4_nwr", 32'(wr_n - f), 0);
    check("t4_done_once", 32'(done_cnt - d0), 1);

    // 5: start pulse and size/slot change mid-photo are ignored
    for (int i = 0; i < 4; i++) begin
      px_r[i] = 8'(i * 60 + 10); px_g[i] = 8'(i * 17); px_b[i] = 8'(250 - i * 9);
    end
    f = wr_n; d0 = done_cnt;
    start(2'd1, 10'd2, 10'd2);
    send(0, 0); send(1, 0);
    i_start = 1'b1; i_photo_sel = 2'd3; iCol_Max = 10'd7; iRow_Max = 10'd9;
    @(negedge clk);
    i_start = 1'b0;
    send(2, 1); send(3, 0);
    wait_done(d0 + 1);
    check_photo("t5", f, 4, 8, 2);
    check("t5_done_once", 32'(done_cnt - d0), 1);

    // 6: reset after three pixels aborts, then a fresh start reloads from base
    for (int i = 0; i < 3; i++) begin
      px_r[i] = 8'(i + 1); px_g[i] = 8'(i + 2); px_b[i] = 8'(i + 3);
    end
    d0 = done_cnt;
    start(2'd0, 10'd4, 10'd4);
    for (int i = 0; i < 3; i++) send(i, 0);
    rst_n = 1'b0;
    #1;
    n0 = wr_n;
    @(negedge clk); #1;
    check("t6_we_n", 32'(oSRAM_WE_N), 1);
    check("t6_busy", 32'(o_busy), 0);
    check("t6_addr", 32'(oSRAM_ADDR), 0);
    check("t6_ready", 32'(o_ready), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t6_no_writes", 32'(wr_n - n0), 0);
    check("t6_no_done", 32'(done_cnt - d0), 0);
    px_r[0] = 8'd9; px_g[0] = 8'd9; px_b[0] = 8'd9;
    f = wr_n;
    start(2'd0, 10'd1, 10'd1);
    send(0, 0);
    wait_done(d0 + 1);
    check("t6_nwr", 32'(wr_n - f), 2);
    check("t6_a0", 32'(wr_addr[f]), 0);
    check("t6_d0", 32'(wr_data[f]), 32'h0909);
    check("t6_a1", 32'(wr_addr[f + 1]), 1);
    check("t6_d1", 32'(wr_data[f + 1]), 32'h0909);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
